// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter among N_REQ byte producers,
// with req_last-based message locking and an idle timeout on the lock.
module uart_tx_arbiter #(
    parameter int N_REQ = 4,
    parameter int DATA_W = 8,
    parameter int LOCK_TIMEOUT = 1024,
    localparam int IW = $clog2(N_REQ),
    localparam int CW = LOCK_TIMEOUT > 1 ? $clog2(LOCK_TIMEOUT) : 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    input  logic [N_REQ-1:0]        req_last,
    output logic [N_REQ-1:0]        req_ready,
    output logic                    tx_start,
    output logic [DATA_W-1:0]       tx_data,
    input  logic                    tx_done_tick,
    output logic                    busy,
    output logic [IW-1:0]           grant_id
);
    typedef enum logic [1:0] {IDLE, START, WAIT, LOCK} state_t;
    state_t state;
    logic [IW-1:0] rr_ptr, win, sel, nxt_ptr;
    logic [CW-1:0] lock_cnt;
    logic found, last_reg, accept, timeout;
    int idx;
    // Scan downward so the last hit is the nearest valid requester at or after rr_ptr.
    always_comb begin
        win = '0;
        found = 1'b0;
        idx = 0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = (int'(rr_ptr) + k) % N_REQ;
            if (req_valid[idx]) begin
                found = 1'b1;
                win = IW'(idx);
            end
        end
    end
    assign sel = state == LOCK ? grant_id : win;
    assign nxt_ptr = grant_id == IW'(N_REQ - 1) ? '0 : grant_id + 1'b1;
    assign timeout = LOCK_TIMEOUT != 0 && 32'(lock_cnt) == LOCK_TIMEOUT - 1;
    always_comb begin
        req_ready = '0;
        if (!reset_n && ((state == IDLE && found) || (state == LOCK && req_valid[grant_id])))
            req_ready[sel] = 1'b1;
    end
    assign accept = |(req_ready & req_valid);
    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            state    <= IDLE;
            tx_start <= 1'b0;
            tx_data  <= '0;
            busy     <= 1'b0;
            grant_id <= '0;
            rr_ptr   <= '0;
            last_reg <= 1'b0;
            lock_cnt <= '0;
        end else begin
            tx_start <= 1'b0;
            if (accept) begin
                tx_data  <= req_data[sel*DATA_W +: DATA_W];
                last_reg <= req_last[sel];
                grant_id <= sel;
                tx_start <= 1'b1;
                busy     <= 1'b1;
                state    <= START;
            end else begin
                case (state)
                    START: state <= WAIT;
                    WAIT: if (tx_done_tick) begin
                        lock_cnt <= '0;
                        if (last_reg) begin
                            rr_ptr <= nxt_ptr;
                            busy   <= 1'b0;
                            state  <= IDLE;
                        end else begin
                            state <= LOCK;
                        end
                    end
                    LOCK: if (timeout) begin
                        rr_ptr <= nxt_ptr;
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        lock_cnt <= lock_cnt + 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares one UART transmitter core (8N1, 16x oversampling, 54 clk per s_tick at 100 MHz) among N_REQ byte producers. Each producer offers bytes over a valid/ready handshake. The arbiter serialises the accepted bytes into single-cycle tx_start pulses and waits for the core's tx_done_tick before it grants again. Multi-byte messages can be kept contiguous with req_last, which locks the grant to one requester until the message ends or a timeout expires.

## Interface
- N_REQ, 4: number of requesters, 2..8
- DATA_W, 8: byte width; must equal UART core data width
- LOCK_TIMEOUT, 1024: clk cycles a locked requester may stay idle before the lock is dropped; 0 disables the timeout
- clk  in  1  system clock, 100 MHz
- reset_n  in  1  reset, asynchronous, active-high
- req_valid  in  N_REQ  requester i has a byte on its data slice
- req_data  in  N_REQ*DATA_W  slice i is bits [i*DATA_W +: DATA_W]
- req_last  in  N_REQ  qualifies the byte as the last of a message
- req_ready  out  N_REQ  one-hot; byte of requester i is accepted at the clock edge where valid&ready
- tx_start  out  1  one-cycle start pulse to the UART core
- tx_data  out  DATA_W  byte to the UART core; stable from tx_start until tx_done_tick
- tx_done_tick  in  1  one-cycle pulse from the UART core at the end of the stop bit
- busy  out  1  high in every state except IDLE
- grant_id  out  clog2(N_REQ)  index of the current or last granted requester

## Operation
- States: IDLE, START, WAIT, LOCK.
- IDLE
  - Winner = first i with req_valid[i], searching from rr_ptr upward, wrapping at N_REQ-1 -> 0.
  - req_ready[winner] = 1 combinationally in the same cycle.
  - At the edge: capture req_data slice into tx_data; capture req_last into last_reg; set grant_id = winner; go to START.
- START: tx_start = 1 for exactly this cycle; go to WAIT.
- WAIT: on tx_done_tick:
  - last_reg = 1: rr_ptr = (grant_id + 1) mod N_REQ; go to IDLE.
  - last_reg = 0: clear lock counter; go to LOCK.
- LOCK
  - Only requester grant_id is eligible. req_ready[grant_id] = req_valid[grant_id].
  - On accept: capture the byte and last bit as in IDLE; go to START.
  - Otherwise the lock counter increments. When it reaches LOCK_TIMEOUT-1 (LOCK_TIMEOUT != 0): rr_ptr = grant_id + 1 mod N_REQ; go to IDLE.
  - Valid from any other requester is ignored.
- tx_done_tick in IDLE, START or LOCK is ignored.
- Requesters hold valid and data stable until they are accepted. A requester may drop valid before acceptance; that withdraws its request, with no side effect.
- rr_ptr changes only on release: end of message or lock timeout.

## Timing
- Reset values: req_ready = 0, tx_start = 0, tx_data = 0, busy = 0, grant_id = 0, rr_ptr = 0, state IDLE, lock counter = 0.
- Reset mid-transfer aborts immediately. The arbiter does not wait for tx_done_tick. UART line state is the core's responsibility.
- Accept edge at cycle 0. tx_start is high during cycle 1. busy is high from cycle 1 until the cycle after tx_done_tick (IDLE). In LOCK, busy stays high until release.
- Next accept:
  - End of message: earliest in the first IDLE cycle after tx_done_tick.
  - LOCK: earliest in the cycle after tx_done_tick.
- Byte-to-byte period on the line is therefore 10 bit times plus 2 clk overhead. One bit time = 16*54 = 864 clk.
- Priority only matters when requests arrive together. The rotation guarantees each continuously-valid requester is served within N_REQ-1 messages.

## Test plan
- Single byte: requester 2 sends 0xAA with last=1.
  - req_ready[2] is high for 1 cycle, then tx_start is high 1 cycle later with tx_data=0xAA.
  - Drive tx_done_tick after 8640 clk. busy falls the next cycle; rr_ptr=3.
- Fairness: all 4 requesters are valid continuously with last=1 and bytes 0x10..0x13.
  - Grant order is 0,1,2,3,0.
  - tx_data order is 0x10,0x11,0x12,0x13,0x10.
- Locked message: requester 1 sends 0x41,0x42,0x43, with last=1 on 0x43; requester 0 is valid throughout.
  - All three bytes are sent before any req_ready[0].
  - grant_id stays 1 until release.
- Lock timeout: requester 3 sends 0x55 with last=0, then drops valid; requester 0 is valid.
  - After tx_done_tick plus LOCK_TIMEOUT cycles, the state returns to IDLE.
  - The next grant goes to 0 (rr_ptr wrapped from 3).
- Spurious and reset:
  - A tx_done_tick in IDLE causes no state change.
  - Asserting reset_n during WAIT clears all outputs asynchronously. After release, a new request is accepted normally.
